// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: index and data
// widths, the "no write" select code and the requester encoding.
package regfile_wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  // Bit 5 set means "no register-file write this cycle".
  localparam logic [5:0] NO_WRITE = 6'b100000;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    data_t;

  // Identifies which requester was granted most recently.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load units, the issue stage and the
// register-file arbiter. The master side is the surrounding pipeline; the
// slave side is the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  // ALU writeback request
  logic       alu_valid;
  reg_idx_t   alu_sel;
  data_t      alu_data;
  logic       alu_ready;

  // Load writeback request
  logic       mem_valid;
  reg_idx_t   mem_sel;
  data_t      mem_data;
  logic       mem_ready;

  // Issue-stage scoreboard access
  logic       reserve_valid;
  reg_idx_t   reserve_sel;
  reg_idx_t   read_a;
  reg_idx_t   read_b;
  logic       stall;

  // Register-file write port
  logic [5:0] write_sel;
  data_t      data_in;

  modport master (
    output alu_valid, alu_sel, alu_data,
    output mem_valid, mem_sel, mem_data,
    output reserve_valid, reserve_sel, read_a, read_b,
    input  alu_ready, mem_ready, stall, write_sel, data_in
  );

  modport slave (
    input  alu_valid, alu_sel, alu_data,
    input  mem_valid, mem_sel, mem_data,
    input  reserve_valid, reserve_sel, read_a, read_b,
    output alu_ready, mem_ready, stall, write_sel, data_in
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Load-hazard scoreboard: one pending bit per architectural register. The
// issue stage sets a bit when it issues a load; the accepted load writeback
// clears it. A same-cycle set wins over a clear. Register 0 never pends.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     set_valid,
  input  reg_idx_t set_sel,
  input  logic     clr_valid,
  input  reg_idx_t clr_sel,
  input  reg_idx_t look_a,
  input  reg_idx_t look_b,
  output logic     pend_a,
  output logic     pend_b
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Decode the set and clear requests into one-hot masks; reserving r0 is dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    set_mask = '0;
    clr_mask = '0;
    if (set_valid && (set_sel != '0)) set_mask[set_sel] = 1'b1;
    if (clr_valid)                    clr_mask[clr_sel] = 1'b1;
  end

  // Update the pending vector; the set mask is applied last so reserve wins.
  always_ff @(posedge clk) begin
    // NOTE: the pending vector is a plain flop bank, not a RAM, so it can and must be cleared by reset.
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  // Lookups read the registered state only, so a same-cycle clear is not forwarded.
  assign pend_a = (look_a != '0) && pending[look_a];
  assign pend_b = (look_b != '0) && pending[look_b];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. Two writeback sources (ALU, load) share a
// single register-file write port. Contention is resolved round-robin, the
// winner's write is registered onto write_sel/data_in one cycle later, and a
// scoreboard of outstanding loads drives the issue-stage stall.
module regfile_wb_arbiter #(
  parameter int         NREG     = 32,
  parameter logic [5:0] NO_WRITE = regfile_wb_arbiter_pkg::NO_WRITE
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  import regfile_wb_arbiter_pkg::*;

  req_e       last_grant;
  logic       grant_alu;
  logic       grant_mem;
  reg_idx_t   win_sel;
  data_t      win_data;
  logic [5:0] write_sel_q;
  data_t      data_in_q;
  logic       pend_a;
  logic       pend_b;

  // Round-robin grant: a lone requester always wins; on contention the
  // requester not granted most recently wins. Nothing is granted in reset.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (bus.alu_valid && bus.mem_valid) begin
        if (last_grant == REQ_MEM) grant_alu = 1'b1;
        else                       grant_mem = 1'b1;
      end else begin
        grant_alu = bus.alu_valid;
        grant_mem = bus.mem_valid;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  // Select the winning request's destination and data.
  always_comb begin
    win_sel  = bus.mem_sel;
    win_data = bus.mem_data;
    if (grant_alu) begin
      win_sel  = bus.alu_sel;
      win_data = bus.alu_data;
    end
  end

  // Last-grant pointer and registered register-file write port. A write to
  // r0 becomes a no-write with zero data; an idle cycle holds data_in.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      last_grant  <= REQ_MEM;
      write_sel_q <= NO_WRITE;
      data_in_q   <= '0;
    end else if (grant_alu || grant_mem) begin
      last_grant <= grant_alu ? REQ_ALU : REQ_MEM;
      if (win_sel == '0) begin
        write_sel_q <= NO_WRITE;
        data_in_q   <= '0;
      end else begin
        write_sel_q <= {1'b0, win_sel};
        data_in_q   <= win_data;
      end
    end else begin
      write_sel_q <= NO_WRITE;
    end
  end

  assign bus.write_sel = write_sel_q;
  assign bus.data_in   = data_in_q;

  wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (bus.reserve_valid),
    .set_sel   (bus.reserve_sel),
    .clr_valid (grant_mem),
    .clr_sel   (bus.mem_sel),
    .look_a    (bus.read_a),
    .look_b    (bus.read_b),
    .pend_a    (pend_a),
    .pend_b    (pend_b)
  );

  assign bus.stall = pend_a | pend_b;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios against
// fixed expected values plus a randomized run against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam logic [5:0] NW = 6'b100000;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .NREG     (32),
    .NO_WRITE (NW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: who was granted last (0 = ALU, 1 = MEM),
  // which registers have a load outstanding, and the write-port contents.
  bit          m_last_mem;
  bit [31:0]   m_pend;
  logic [5:0]  m_wsel;
  logic [31:0] m_data;

  // Observed and expected values of the most recent step.
  logic        obs_ar, obs_mr, obs_stall;
  logic [5:0]  obs_wsel;
  logic [31:0] obs_data;
  logic        exp_ar, exp_mr, exp_stall;
  logic [5:0]  exp_wsel;
  logic [31:0] exp_data;

  // One clock cycle: apply inputs, predict and sample the combinational
  // outputs before the edge, advance the model, sample registered outputs.
  task automatic step(input bit r, input bit av, input logic [4:0] asel, input logic [31:0] ad,
                      input bit mv, input logic [4:0] msel, input logic [31:0] md,
                      input bit rv, input logic [4:0] rsel,
                      input logic [4:0] ra, input logic [4:0] rb);
    reset             = r;
    bus.alu_valid     = av;
    bus.alu_sel       = asel;
    bus.alu_data      = ad;
    bus.mem_valid     = mv;
    bus.mem_sel       = msel;
    bus.mem_data      = md;
    bus.reserve_valid = rv;
    bus.reserve_sel   = rsel;
    bus.read_a        = ra;
    bus.read_b        = rb;
    #1;
    exp_ar = 1'b0;
    exp_mr = 1'b0;
    if (!r) begin
      if (av && mv) begin
        exp_ar = m_last_mem;
        exp_mr = !m_last_mem;
      end else begin
        exp_ar = av;
        exp_mr = mv;
      end
    end
    exp_stall = m_pend[ra] | m_pend[rb];
    obs_ar    = bus.alu_ready;
    obs_mr    = bus.mem_ready;
    obs_stall = bus.stall;
    @(posedge clk);
    #1;
    if (r) begin
      m_last_mem = 1'b1;
      m_pend     = '0;
      m_wsel     = NW;
      m_data     = '0;
    end else begin
      m_wsel = NW;
      if (exp_ar) begin
        m_last_mem = 1'b0;
        m_wsel     = (asel == 0) ? NW : {1'b0, asel};
        m_data     = (asel == 0) ? 32'h0 : ad;
      end
      if (exp_mr) begin
        m_last_mem    = 1'b1;
        m_wsel        = (msel == 0) ? NW : {1'b0, msel};
        m_data        = (msel == 0) ? 32'h0 : md;
        m_pend[msel]  = 1'b0;
      end
      if (rv && rsel != 0) m_pend[rsel] = 1'b1;
    end
    exp_wsel = m_wsel;
    exp_data = m_data;
    obs_wsel = bus.write_sel;
    obs_data = bus.data_in;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  task automatic test_reset();
    step(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 1, 5'd6, 5'd6, 5'd0);
    n_cmp++;
    if ({obs_ar, obs_mr} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", {obs_ar, obs_mr});
    end
    n_cmp++;
    if ({obs_wsel, obs_data} !== {NW, 32'h0}) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h expected %h/0", obs_wsel, obs_data, NW);
    end
    idle(5'd6, 5'd0);
    n_cmp++;
    if ({obs_stall, obs_wsel} !== {1'b0, NW}) begin
      n_fail++; $display("FAIL reset_dropped: stall/wsel got %b/%h expected 0/%h", obs_stall, obs_wsel, NW);
    end
  endtask

  task automatic test_alu_only();
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({obs_ar, obs_wsel, obs_data} !== {1'b1, 6'b000101, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL alu_only: got %b/%h/%h expected 1/05/deadbeef", obs_ar, obs_wsel, obs_data);
    end
    idle(0, 0);
    n_cmp++;
    if ({obs_wsel, obs_data} !== {NW, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL alu_idle_hold: got %h/%h expected %h/deadbeef", obs_wsel, obs_data, NW);
    end
  endtask

  task automatic test_contention();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] want_grant;
      logic [5:0] want_sel;
      want_grant = (i % 2 == 0) ? 2'b10 : 2'b01;
      want_sel   = (i % 2 == 0) ? 6'd3 : 6'd4;
      step(0, 1, 5'd3, 32'hA000_0000 + i, 1, 5'd4, 32'hB000_0000 + i, 0, 0, 0, 0);
      n_cmp++;
      if ({obs_ar, obs_mr, obs_wsel} !== {want_grant, want_sel}) begin
        n_fail++; $display("FAIL contention[%0d]: grant/wsel got %b/%0d expected %b/%0d",
                           i, {obs_ar, obs_mr}, obs_wsel, want_grant, want_sel);
      end
    end
  endtask

  task automatic test_reg0();
    step(0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({obs_ar, obs_wsel, obs_data} !== {1'b1, NW, 32'h0}) begin
      n_fail++; $display("FAIL reg0_write: got %b/%h/%h expected 1/%h/0", obs_ar, obs_wsel, obs_data, NW);
    end
  endtask

  task automatic test_load_hazard();
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    n_cmp++;
    if (obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL hazard_reserve_cycle: stall got %b expected 0", obs_stall);
    end
    idle(5'd7, 0);
    n_cmp++;
    if (obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL hazard_pending: stall got %b expected 1", obs_stall);
    end
    step(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0);
    n_cmp++;
    if ({obs_mr, obs_stall} !== 2'b11) begin
      n_fail++; $display("FAIL hazard_clear_cycle: ready/stall got %b expected 11", {obs_mr, obs_stall});
    end
    idle(5'd7, 0);
    n_cmp++;
    if (obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL hazard_cleared: stall got %b expected 0", obs_stall);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    step(0, 1, 5'd7, 32'h5, 0, 0, 0, 0, 0, 5'd7, 0);
    n_cmp++;
    if ({obs_ar, obs_stall} !== 2'b11) begin
      n_fail++; $display("FAIL hazard_alu_write: ready/stall got %b expected 11", {obs_ar, obs_stall});
    end
    idle(5'd7, 0);
    n_cmp++;
    if (obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL hazard_alu_no_clear: stall got %b expected 1", obs_stall);
    end
    step(0, 0, 0, 0, 1, 5'd7, 32'h7, 0, 0, 0, 0);
  endtask

  task automatic test_collision();
    step(0, 0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 0, 5'd9);
    n_cmp++;
    if (obs_mr !== 1'b1) begin
      n_fail++; $display("FAIL collision_accept: mem_ready got %b expected 1", obs_mr);
    end
    idle(0, 5'd9);
    n_cmp++;
    if (obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL collision_reserve_wins: stall got %b expected 1", obs_stall);
    end
  endtask

  task automatic test_reset_midstream();
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0);
    step(0, 1, 5'd10, 32'h10, 1, 5'd11, 32'h11, 0, 0, 5'd2, 5'd8);
    n_cmp++;
    if (obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL midreset_before: stall got %b expected 1", obs_stall);
    end
    step(1, 1, 5'd10, 32'h10, 1, 5'd11, 32'h11, 0, 0, 5'd2, 5'd8);
    n_cmp++;
    if ({obs_ar, obs_mr, obs_wsel} !== {2'b00, NW}) begin
      n_fail++; $display("FAIL midreset_during: ready/wsel got %b/%h expected 00/%h", {obs_ar, obs_mr}, obs_wsel, NW);
    end
    idle(5'd2, 5'd8);
    n_cmp++;
    if (obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL midreset_stall: stall got %b expected 0", obs_stall);
    end
    step(0, 1, 5'd12, 32'h12, 1, 5'd13, 32'h13, 0, 0, 0, 0);
    n_cmp++;
    if ({obs_ar, obs_mr, obs_wsel} !== {2'b10, 6'd12}) begin
      n_fail++; $display("FAIL midreset_alu_first: grant/wsel got %b/%0d expected 10/12", {obs_ar, obs_mr}, obs_wsel);
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 59) == 0);
      step(r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      n_cmp++;
      if ({obs_ar, obs_mr, obs_stall, obs_wsel, obs_data} !==
          {exp_ar, exp_mr, exp_stall, exp_wsel, exp_data}) begin
        n_fail++;
        $display("FAIL random[%0d]: got ar=%b mr=%b st=%b ws=%h d=%h expected ar=%b mr=%b st=%b ws=%h d=%h",
                 i, obs_ar, obs_mr, obs_stall, obs_wsel, obs_data,
                 exp_ar, exp_mr, exp_stall, exp_wsel, exp_data);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_last_mem = 1'b1;
    m_pend     = '0;
    m_wsel     = NW;
    m_data     = '0;
    reset             = 1'b1;
    bus.alu_valid     = 1'b0;
    bus.alu_sel       = '0;
    bus.alu_data      = '0;
    bus.mem_valid     = 1'b0;
    bus.mem_sel       = '0;
    bus.mem_data      = '0;
    bus.reserve_valid = 1'b0;
    bus.reserve_sel   = '0;
    bus.read_a        = '0;
    bus.read_b        = '0;
    @(negedge clk);
    test_reset();
    test_alu_only();
    test_contention();
    test_reg0();
    test_load_hazard();
    test_collision();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: NREG, default 32, number of architectural registers; only 32 is supported.
REQ-002 Parameter: NO_WRITE, default 6'b100000, write_sel code for "no write"; bit 5 set suppresses the write and the bypass.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_sel  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle (combinational).
REQ-009 mem_valid  input  1  load writeback request.
REQ-010 mem_sel  input  5  load destination register.
REQ-011 mem_data  input  32  load data.
REQ-012 mem_ready  output  1  load request accepted this cycle (combinational).
REQ-013 reserve_valid  input  1  issue stage marks a load destination as pending.
REQ-014 reserve_sel  input  5  register being reserved.
REQ-015 read_a, read_b  input  5 each  source registers of the instruction in issue.
REQ-016 stall  output  1  an issue-stage source is pending (combinational).
REQ-017 write_sel  output  6  register-file write select; registered.
REQ-018 data_in  output  32  register-file write data; registered.

Function
REQ-019 Only one request SHALL be granted per cycle; a request is accepted when valid and ready are both high in the same cycle.
REQ-020 When exactly one requester is valid, that requester SHALL be granted.
REQ-021 When both are valid, the requester not granted most recently SHALL be granted (round-robin); the last-grant pointer SHALL update on every grant.
REQ-022 The ready outputs SHALL be low while reset is high.
REQ-023 An accepted request SHALL drive write_sel={1'b0,sel} and data_in=data on the following cycle, giving one cycle of latency.
REQ-024 Accepted requests with sel==0 SHALL drive write_sel=NO_WRITE and data_in=0.
REQ-025 In cycles following no grant, write_sel SHALL equal NO_WRITE and data_in SHALL hold its previous value.
REQ-026 The scoreboard SHALL hold one pending bit per register.
REQ-027 reserve_valid with reserve_sel!=0 SHALL set the pending bit at the next edge; reserving register 0 SHALL be ignored.
REQ-028 An accepted mem request SHALL clear pending[mem_sel] at the next edge.
REQ-029 An accepted alu request SHALL NOT change pending.
REQ-030 Reserve and clear of the same register in the same cycle SHALL leave the bit set (reserve wins).
REQ-031 Re-reserving an already pending register SHALL leave it set, with no count kept.
REQ-032 stall SHALL equal pending[read_a] | pending[read_b]; pending[0] SHALL always read 0.
REQ-033 stall SHALL NOT be forwarded from a same-cycle clear; it drops on the cycle after the clearing grant, aligned with write_sel.

Reset
REQ-034 Reset SHALL set write_sel=NO_WRITE, data_in=0, all pending bits to 0, and the last-grant pointer to MEM, so that ALU wins the first contention.
REQ-035 Requests presented during reset SHALL be dropped, not queued.
REQ-036 A reset asserted mid-operation SHALL discard outstanding reservations, with stall low from the cycle after reset.

Structure
REQ-037 A shared package SHALL hold the NO_WRITE constant, the requester encoding (REQ_ALU=0, REQ_MEM=1) and the register-index width (5).
REQ-038 The scoreboard SHALL be a sub-module wb_scoreboard (pending vector, set/clear ports, two combinational lookup ports); arbitration and output registers SHALL stay in regfile_wb_arbiter.

Verification
REQ-039 Scenario, ALU only: alu_valid=1, alu_sel=5, alu_data=32'hDEAD_BEEF -> alu_ready=1 the same cycle; write_sel=6'b000101, data_in=32'hDEAD_BEEF the next cycle, then NO_WRITE.
REQ-040 Scenario, contention after reset: both requesters valid for 4 cycles (alu_sel=3, mem_sel=4) -> grants ALU, MEM, ALU, MEM; write_sel sequence 3, 4, 3, 4.
REQ-041 Scenario, register 0: alu_sel=0, alu_data=32'h1234 -> accepted; write_sel=NO_WRITE, data_in=0.
REQ-042 Scenario, load hazard: reserve r7; read_a=7 -> stall=1 from the next cycle; mem write to r7 accepted -> stall=0 from the cycle after, and an ALU write to r7 leaves stall=1.
REQ-043 Scenario, reserve/clear collision: reserve r9 in the same cycle as an accepted mem write to r9 -> pending[9] stays 1 and stall=1 with read_b=9.
REQ-044 Scenario, reset mid-stream: pending r2 and r8, both requesters active, assert reset for 1 cycle -> ready=0 during reset; afterwards stall=0 for read_a=2/read_b=8, write_sel=NO_WRITE, and ALU wins the next contention.
